// File: rtl/osd_axi4lite_if.sv
// AXI4-Lite slave front end for the OSD register file: independent write and read
// paths that turn AXI handshakes into single-cycle register strobes.
module osd_axi4lite_if #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  mem_wr_valid,
    output logic [31:0]           mem_wr_addr,
    output logic [31:0]           mem_wr_data,
    output logic                  mem_rd_valid,
    output logic [31:0]           mem_rd_addr,
    input  logic [31:0]           mem_rd_data
);

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] awaddr_reg;
    logic [31:0]           wdata_reg;
    logic [3:0]            wstrb_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;
    logic                  mem_wr_valid_reg;
    logic [31:0]           mem_wr_addr_reg, mem_wr_data_reg;

    r_state_t              r_state;
    logic                  rd_err_reg;
    logic                  rvalid_reg;
    logic [1:0]            rresp_reg;
    logic [31:0]           rdata_reg;
    logic                  mem_rd_valid_reg;
    logic [31:0]           mem_rd_addr_reg;

    logic                  aw_hs, w_hs, wr_issue, wr_ok;
    logic [ADDR_WIDTH-1:0] wr_addr_eff;
    logic [31:0]           wr_data_eff;
    logic [3:0]            wr_strb_eff;

    // Readies are gated by aresetn so they are low during reset and high in
    // the very first cycle after release.
    assign s_axi_awready = aresetn && !aw_held && !bvalid_reg;
    assign s_axi_wready  = aresetn && !w_held && !bvalid_reg;
    assign s_axi_arready = aresetn && (r_state == R_IDLE);

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;

    // A beat arriving this cycle is used directly so same-cycle AW/W issues at once.
    assign wr_addr_eff = aw_held ? awaddr_reg : s_axi_awaddr;
    assign wr_data_eff = w_held ? wdata_reg : s_axi_wdata;
    assign wr_strb_eff = w_held ? wstrb_reg : s_axi_wstrb;
    assign wr_issue    = (aw_held || aw_hs) && (w_held || w_hs) && !bvalid_reg;
    assign wr_ok       = (wr_addr_eff[1:0] == 2'b00) && (wr_strb_eff == 4'hF);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held          <= 1'b0;
            w_held           <= 1'b0;
            awaddr_reg       <= '0;
            wdata_reg        <= '0;
            wstrb_reg        <= '0;
            bvalid_reg       <= 1'b0;
            bresp_reg        <= 2'b00;
            mem_wr_valid_reg <= 1'b0;
            mem_wr_addr_reg  <= '0;
            mem_wr_data_reg  <= '0;
        end else begin
            mem_wr_valid_reg <= 1'b0;
            if (bvalid_reg) begin
                if (s_axi_bready) begin
                    aw_held    <= 1'b0;
                    w_held     <= 1'b0;
                    bvalid_reg <= 1'b0;
                end
            end else begin
                if (aw_hs) begin
                    aw_held    <= 1'b1;
                    awaddr_reg <= s_axi_awaddr;
                end
                if (w_hs) begin
                    w_held    <= 1'b1;
                    wdata_reg <= s_axi_wdata;
                    wstrb_reg <= s_axi_wstrb;
                end
                if (wr_issue) begin
                    bvalid_reg       <= 1'b1;
                    bresp_reg        <= wr_ok ? 2'b00 : 2'b10;
                    mem_wr_valid_reg <= wr_ok;
                    mem_wr_addr_reg  <= 32'(wr_addr_eff);
                    mem_wr_data_reg  <= wr_data_eff;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state          <= R_IDLE;
            rd_err_reg       <= 1'b0;
            rvalid_reg       <= 1'b0;
            rresp_reg        <= 2'b00;
            rdata_reg        <= '0;
            mem_rd_valid_reg <= 1'b0;
            mem_rd_addr_reg  <= '0;
        end else begin
            mem_rd_valid_reg <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    if (s_axi_arvalid) begin
                        mem_rd_addr_reg  <= 32'(s_axi_araddr);
                        rd_err_reg       <= (s_axi_araddr[1:0] != 2'b00);
                        mem_rd_valid_reg <= (s_axi_araddr[1:0] == 2'b00);
                        r_state          <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rvalid_reg <= 1'b1;
                    rdata_reg  <= rd_err_reg ? 32'h0 : mem_rd_data;
                    rresp_reg  <= rd_err_reg ? 2'b10 : 2'b00;
                    r_state    <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        rvalid_reg <= 1'b0;
                        r_state    <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign s_axi_bvalid = bvalid_reg;
    assign s_axi_bresp  = bresp_reg;
    assign s_axi_rvalid = rvalid_reg;
    assign s_axi_rresp  = rresp_reg;
    assign s_axi_rdata  = rdata_reg;
    assign mem_wr_valid = mem_wr_valid_reg;
    assign mem_wr_addr  = mem_wr_addr_reg;
    assign mem_wr_data  = mem_wr_data_reg;
    assign mem_rd_valid = mem_rd_valid_reg;
    assign mem_rd_addr  = mem_rd_addr_reg;

endmodule

// File: tb/tb_osd_axi4lite_if.sv
// Directed bench for osd_axi4lite_if: write/read paths, error responses,
// back-pressure, throughput and mid-transaction reset.
module tb_osd_axi4lite_if;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        mem_wr_valid;
    logic [31:0] mem_wr_addr, mem_wr_data;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_addr, mem_rd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;

    osd_axi4lite_if #(.ADDR_WIDTH(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
    );

    always #5 aclk = ~aclk;

    // Strobe counters sample mid-cycle, away from the active edge.
    always @(negedge aclk) begin
        if (mem_wr_valid === 1'b1) wr_pulses++;
        if (mem_rd_valid === 1'b1) rd_pulses++;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
        s_axi_bready = 0; s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_rready = 0; mem_rd_data = 0;
        tick(); tick();
        n_checks++; if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, mem_wr_valid, mem_rd_valid} !== 7'b0) begin n_fail++; $display("FAIL rst_handshake: got %b expected 0000000", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, mem_wr_valid, mem_rd_valid}); end
        n_checks++; if ({s_axi_bresp, s_axi_rresp, s_axi_rdata, mem_wr_addr, mem_wr_data, mem_rd_addr} !== 132'h0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", {s_axi_bresp, s_axi_rresp, s_axi_rdata, mem_wr_addr, mem_wr_data, mem_rd_addr}); end
        aresetn = 1'b1;
        #1;
        n_checks++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 111", {s_axi_awready, s_axi_wready, s_axi_arready}); end
        tick();
        $display("reset released");
    endtask

    task automatic test_same_cycle_write();
        s_axi_awvalid = 1; s_axi_awaddr = 32'h04; s_axi_wvalid = 1; s_axi_wdata = 32'h00FF00FF; s_axi_wstrb = 4'hF;
        tick();
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        n_checks++; if (mem_wr_valid !== 1'b1) begin n_fail++; $display("FAIL wr_same_strobe: got %b expected 1", mem_wr_valid); end
        n_checks++; if (mem_wr_addr !== 32'h04 || mem_wr_data !== 32'h00FF00FF) begin n_fail++; $display("FAIL wr_same_payload: got %h/%h expected 00000004/00ff00ff", mem_wr_addr, mem_wr_data); end
        n_checks++; if ({s_axi_bvalid, s_axi_bresp, s_axi_awready} !== 4'b1000) begin n_fail++; $display("FAIL wr_same_resp: got %b expected 1000", {s_axi_bvalid, s_axi_bresp, s_axi_awready}); end
        tick();
        n_checks++; if ({mem_wr_valid, s_axi_bvalid} !== 2'b01) begin n_fail++; $display("FAIL wr_same_hold: got %b expected 01", {mem_wr_valid, s_axi_bvalid}); end
        s_axi_bready = 1;
        tick();
        s_axi_bready = 0;
        n_checks++; if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b011) begin n_fail++; $display("FAIL wr_same_done: got %b expected 011", {s_axi_bvalid, s_axi_awready, s_axi_wready}); end
        $display("write addr=%h data=%h bresp=%b", 32'h04, 32'h00FF00FF, 2'b00);
    endtask

    task automatic test_w_before_aw();
        int p0 = wr_pulses;
        s_axi_wvalid = 1; s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF;
        tick();
        s_axi_wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({s_axi_wready, mem_wr_valid, s_axi_bvalid} !== 3'b000) begin n_fail++; $display("FAIL wfirst_wait%0d: got %b expected 000", i, {s_axi_wready, mem_wr_valid, s_axi_bvalid}); end
            if (i < 2) tick();
        end
        s_axi_awvalid = 1; s_axi_awaddr = 32'h08;
        tick();
        s_axi_awvalid = 0;
        n_checks++; if ({mem_wr_valid, s_axi_bvalid, s_axi_bresp, s_axi_wready} !== 5'b11000) begin n_fail++; $display("FAIL wfirst_issue: got %b expected 11000", {mem_wr_valid, s_axi_bvalid, s_axi_bresp, s_axi_wready}); end
        n_checks++; if (mem_wr_addr !== 32'h08 || mem_wr_data !== 32'h12345678) begin n_fail++; $display("FAIL wfirst_payload: got %h/%h expected 00000008/12345678", mem_wr_addr, mem_wr_data); end
        s_axi_bready = 1;
        tick();
        s_axi_bready = 0;
        tick();
        n_checks++; if (s_axi_wready !== 1'b1) begin n_fail++; $display("FAIL wfirst_wready_back: got %b expected 1", s_axi_wready); end
        n_checks++; if (wr_pulses - p0 !== 1) begin n_fail++; $display("FAIL wfirst_pulses: got %0d expected 1", wr_pulses - p0); end
        $display("write addr=%h data=%h (W first)", 32'h08, 32'h12345678);
    endtask

    task automatic test_slverr();
        logic [31:0] addrs [2] = '{32'h06, 32'h00};
        logic [3:0]  strbs [2] = '{4'hF, 4'h3};
        for (int k = 0; k < 2; k++) begin
            int p0 = wr_pulses;
            s_axi_awvalid = 1; s_axi_awaddr = addrs[k]; s_axi_wvalid = 1; s_axi_wdata = 32'hBAD0BAD0; s_axi_wstrb = strbs[k];
            tick();
            s_axi_awvalid = 0; s_axi_wvalid = 0;
            n_checks++; if ({mem_wr_valid, s_axi_bvalid, s_axi_bresp} !== 4'b0110) begin n_fail++; $display("FAIL slverr%0d_resp: got %b expected 0110", k, {mem_wr_valid, s_axi_bvalid, s_axi_bresp}); end
            for (int i = 0; i < 5; i++) tick();
            n_checks++; if ({s_axi_bvalid, s_axi_bresp} !== 3'b110) begin n_fail++; $display("FAIL slverr%0d_hold: got %b expected 110", k, {s_axi_bvalid, s_axi_bresp}); end
            s_axi_bready = 1;
            tick();
            s_axi_bready = 0;
            n_checks++; if (s_axi_bvalid !== 1'b0 || wr_pulses != p0) begin n_fail++; $display("FAIL slverr%0d_done: got bvalid=%b pulses=%0d expected 0/0", k, s_axi_bvalid, wr_pulses - p0); end
            $display("write addr=%h strb=%h bresp=10", addrs[k], strbs[k]);
        end
    endtask

    task automatic test_read();
        int p0;
        mem_rd_data = 32'hCAFEF00D;
        s_axi_arvalid = 1; s_axi_araddr = 32'h0C;
        n_checks++; if (s_axi_arready !== 1'b1) begin n_fail++; $display("FAIL rd_arready: got %b expected 1", s_axi_arready); end
        tick();
        s_axi_arvalid = 0;
        n_checks++; if ({mem_rd_valid, s_axi_rvalid, s_axi_arready} !== 3'b100 || mem_rd_addr !== 32'h0C) begin n_fail++; $display("FAIL rd_fetch: got %b addr=%h expected 100 addr=0000000c", {mem_rd_valid, s_axi_rvalid, s_axi_arready}, mem_rd_addr); end
        tick();
        mem_rd_data = 32'h11111111;
        n_checks++; if ({s_axi_rvalid, s_axi_rresp, mem_rd_valid} !== 4'b1000 || s_axi_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rd_data: got %b rdata=%h expected 1000 rdata=cafef00d", {s_axi_rvalid, s_axi_rresp, mem_rd_valid}, s_axi_rdata); end
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rd_stable: got rvalid=%b rdata=%h expected 1/cafef00d", s_axi_rvalid, s_axi_rdata); end
        s_axi_rready = 1;
        tick();
        s_axi_rready = 0;
        n_checks++; if ({s_axi_rvalid, s_axi_arready} !== 2'b01) begin n_fail++; $display("FAIL rd_done: got %b expected 01", {s_axi_rvalid, s_axi_arready}); end
        $display("read addr=%h rdata=%h rresp=00", 32'h0C, 32'hCAFEF00D);
        // Misaligned read: no strobe, zero data, SLVERR.
        p0 = rd_pulses;
        s_axi_arvalid = 1; s_axi_araddr = 32'h0D;
        tick();
        s_axi_arvalid = 0;
        tick();
        n_checks++; if ({s_axi_rvalid, s_axi_rresp} !== 3'b110 || s_axi_rdata !== 32'h0 || rd_pulses != p0) begin n_fail++; $display("FAIL rd_misaligned: got %b rdata=%h pulses=%0d expected 110/0/0", {s_axi_rvalid, s_axi_rresp}, s_axi_rdata, rd_pulses - p0); end
        s_axi_rready = 1;
        tick();
        s_axi_rready = 0;
        $display("read addr=%h rresp=10", 32'h0D);
    endtask

    task automatic test_concurrent();
        mem_rd_data = 32'hA5A50014;
        s_axi_awvalid = 1; s_axi_awaddr = 32'h10; s_axi_wvalid = 1; s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF;
        s_axi_arvalid = 1; s_axi_araddr = 32'h14; s_axi_bready = 1; s_axi_rready = 1;
        tick();
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
        n_checks++; if ({mem_wr_valid, mem_rd_valid, s_axi_bvalid} !== 3'b111) begin n_fail++; $display("FAIL conc_strobes: got %b expected 111", {mem_wr_valid, mem_rd_valid, s_axi_bvalid}); end
        n_checks++; if (mem_wr_addr !== 32'h10 || mem_wr_data !== 32'hDEADBEEF || mem_rd_addr !== 32'h14) begin n_fail++; $display("FAIL conc_addr: got %h/%h/%h expected 00000010/deadbeef/00000014", mem_wr_addr, mem_wr_data, mem_rd_addr); end
        tick();
        n_checks++; if ({s_axi_bvalid, s_axi_rvalid, s_axi_rresp} !== 4'b0100 || s_axi_rdata !== 32'hA5A50014 || mem_wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL conc_data: got %b rdata=%h wdata=%h expected 0100/a5a50014/deadbeef", {s_axi_bvalid, s_axi_rvalid, s_axi_rresp}, s_axi_rdata, mem_wr_data); end
        tick();
        s_axi_bready = 0; s_axi_rready = 0;
        $display("concurrent write 10=%h read 14=%h", 32'hDEADBEEF, 32'hA5A50014);
    endtask

    task automatic test_back_to_back();
        int p0 = wr_pulses;
        s_axi_bready = 1;
        s_axi_awvalid = 1; s_axi_awaddr = 32'h20; s_axi_wvalid = 1; s_axi_wdata = 32'h0BADF00D; s_axi_wstrb = 4'hF;
        for (int i = 0; i < 8; i++) tick();
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        tick();
        n_checks++; if (wr_pulses - p0 !== 4) begin n_fail++; $display("FAIL b2b_writes: got %0d expected 4", wr_pulses - p0); end
        s_axi_bready = 0;
        p0 = rd_pulses;
        mem_rd_data = 32'h00000020;
        s_axi_rready = 1; s_axi_arvalid = 1; s_axi_araddr = 32'h20;
        for (int i = 0; i < 9; i++) tick();
        s_axi_arvalid = 0;
        tick();
        n_checks++; if (rd_pulses - p0 !== 3) begin n_fail++; $display("FAIL b2b_reads: got %0d expected 3", rd_pulses - p0); end
        tick();
        s_axi_rready = 0;
        $display("back-to-back: 4 writes in 8 cycles, 3 reads in 9 cycles");
    endtask

    task automatic test_reset_mid();
        int p0;
        // Reset while a write response is pending.
        s_axi_awvalid = 1; s_axi_awaddr = 32'h18; s_axi_wvalid = 1; s_axi_wdata = 32'h55AA55AA; s_axi_wstrb = 4'hF;
        tick();
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        tick();
        aresetn = 1'b0;
        #1;
        n_checks++; if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, mem_wr_valid, mem_rd_valid} !== 7'b0 || mem_wr_addr !== 32'h0 || mem_wr_data !== 32'h0 || s_axi_bresp !== 2'b00) begin n_fail++; $display("FAIL rstmid_wr_outputs: got %b addr=%h data=%h", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, mem_wr_valid, mem_rd_valid}, mem_wr_addr, mem_wr_data); end
        tick(); tick();
        p0 = wr_pulses;
        aresetn = 1'b1;
        #1;
        n_checks++; if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b110) begin n_fail++; $display("FAIL rstmid_wr_release: got %b expected 110", {s_axi_awready, s_axi_wready, s_axi_bvalid}); end
        tick(); tick(); tick();
        n_checks++; if (wr_pulses != p0 || s_axi_bvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_wr_nostrobe: got pulses=%0d bvalid=%b expected 0/0", wr_pulses - p0, s_axi_bvalid); end
        // Reset during R_FETCH.
        mem_rd_data = 32'h77778888;
        s_axi_arvalid = 1; s_axi_araddr = 32'h1C;
        tick();
        s_axi_arvalid = 0;
        aresetn = 1'b0;
        #1;
        n_checks++; if ({s_axi_arready, s_axi_rvalid, mem_rd_valid} !== 3'b000 || s_axi_rdata !== 32'h0 || mem_rd_addr !== 32'h0 || s_axi_rresp !== 2'b00) begin n_fail++; $display("FAIL rstmid_rd_outputs: got %b rdata=%h addr=%h", {s_axi_arready, s_axi_rvalid, mem_rd_valid}, s_axi_rdata, mem_rd_addr); end
        tick();
        p0 = rd_pulses;
        aresetn = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (rd_pulses != p0 || s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin n_fail++; $display("FAIL rstmid_rd_nostrobe: got pulses=%0d rvalid=%b arready=%b expected 0/0/1", rd_pulses - p0, s_axi_rvalid, s_axi_arready); end
        // Normal traffic resumes.
        s_axi_awvalid = 1; s_axi_awaddr = 32'h18; s_axi_wvalid = 1; s_axi_wdata = 32'h13572468; s_axi_wstrb = 4'hF;
        s_axi_arvalid = 1; s_axi_araddr = 32'h1C; s_axi_bready = 1; s_axi_rready = 1;
        tick();
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
        n_checks++; if ({mem_wr_valid, s_axi_bvalid, s_axi_bresp, mem_rd_valid} !== 5'b11001 || mem_wr_data !== 32'h13572468) begin n_fail++; $display("FAIL rstmid_resume_wr: got %b data=%h expected 11001/13572468", {mem_wr_valid, s_axi_bvalid, s_axi_bresp, mem_rd_valid}, mem_wr_data); end
        tick();
        n_checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h77778888) begin n_fail++; $display("FAIL rstmid_resume_rd: got rvalid=%b rdata=%h expected 1/77778888", s_axi_rvalid, s_axi_rdata); end
        tick();
        s_axi_bready = 0; s_axi_rready = 0;
        $display("reset mid-transaction recovered: write 18=%h read 1c=%h", 32'h13572468, 32'h77778888);
    endtask

    initial begin
        test_reset();
        test_same_cycle_write();
        test_w_before_aw();
        test_slverr();
        test_read();
        test_concurrent();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/osd_axi4lite_if.md
OSD_AXI4LITE_IF -- requirements
Module: osd_axi4lite_if

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32: width of the AXI address and mem_*_addr buses.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- aclk, in, 1: clock.
- aresetn, in, 1: asynchronous active-low reset.
- s_axi_awvalid/awready, in/out, 1: write address handshake.
- s_axi_awaddr, in, ADDR_WIDTH: write address.
- s_axi_wvalid/wready, in/out, 1: write data handshake.
- s_axi_wdata, in, 32: write data.
- s_axi_wstrb, in, 4: byte strobes.
- s_axi_bvalid/bready, out/in, 1: write response handshake.
- s_axi_bresp, out, 2: write response.
- s_axi_arvalid/arready, in/out, 1: read address handshake.
- s_axi_araddr, in, ADDR_WIDTH: read address.
- s_axi_rvalid/rready, out/in, 1: read data handshake.
- s_axi_rdata, out, 32: read data.
- s_axi_rresp, out, 2: read response.
- mem_wr_valid, out, 1: one-cycle register write strobe to the OSD register file.
- mem_wr_addr, out, 32: write address, zero-extended from ADDR_WIDTH.
- mem_wr_data, out, 32: write data.
- mem_rd_valid, out, 1: one-cycle register read strobe.
- mem_rd_addr, out, 32: read address, zero-extended.
- mem_rd_data, in, 32: read data, valid in the cycle after mem_rd_valid.
REQ-003 Reset SHALL be aresetn (asynchronous, active-low) and the clock SHALL be aclk.

Function
REQ-004 The write path SHALL capture AW and W independently into held registers (aw_held, w_held), in either order or in the same cycle.
REQ-005 s_axi_awready SHALL be 1 iff !aw_held and bvalid=0; s_axi_wready SHALL be 1 iff !w_held and bvalid=0.
REQ-006 Issue timing: if both are held (or handshaken) at the clock edge ending cycle N, the block SHALL drive mem_wr_valid=1 for exactly cycle N+1 and assert s_axi_bvalid in cycle N+1.
REQ-007 The write SHALL be valid only if awaddr[1:0]=0 and wstrb=4'hF.
- Valid write: mem_wr_valid pulses; bresp=2'b00.
- Invalid write: mem_wr_valid stays 0; bresp=2'b10 (SLVERR).
REQ-008 mem_wr_addr/mem_wr_data SHALL hold the captured values from the pulse cycle until the next capture.
REQ-009 bvalid and bresp SHALL stay stable until bready=1. On the bready handshake edge, aw_held, w_held and bvalid SHALL clear, and a new AW/W may be accepted in the following cycle.
REQ-010 The read FSM SHALL have states R_IDLE, R_FETCH, R_DATA, with arready=1 only in R_IDLE.
- R_IDLE -> R_FETCH on arvalid&arready: latch araddr; mem_rd_valid=1 during R_FETCH.
- R_FETCH -> R_DATA unconditionally:
  - aligned address: capture mem_rd_data into rdata, rresp=2'b00;
  - araddr[1:0]!=0: rdata=0, rresp=2'b10, and mem_rd_valid SHALL NOT pulse.
- R_DATA -> R_IDLE on rvalid&rready.
REQ-011 Read latency SHALL be: AR handshake at edge N gives rvalid=1 in cycle N+2. rdata/rresp SHALL be stable while rvalid=1 and rready=0.
REQ-012 Read and write paths SHALL be fully independent; simultaneous mem_wr_valid and mem_rd_valid in the same cycle SHALL be permitted.
REQ-013 Throughput: back-to-back writes SHALL complete at one per 2 cycles with bready tied high; back-to-back reads at one per 3 cycles with rready tied high.

Reset
REQ-014 While aresetn=0, all ready, valid and strobe outputs SHALL be 0, except arready=1 in R_IDLE after deassertion.
REQ-015 While aresetn=0:
- bresp, rresp, rdata, mem_wr_addr, mem_wr_data and mem_rd_addr SHALL be 0;
- the held flags SHALL be 0;
- the read FSM SHALL be in R_IDLE.
REQ-016 Reset asserted mid-transaction SHALL abandon the transaction with no mem_wr_valid/mem_rd_valid pulse after deassertion. awready=wready=1 SHALL hold in the first cycle after deassertion.

Verification
REQ-017 AW 0x04 and W 0x00FF00FF, wstrb F, in the same cycle -> next cycle mem_wr_valid=1, mem_wr_addr=0x04, mem_wr_data=0x00FF00FF, bvalid=1, bresp=00.
REQ-018 W 0x12345678 three cycles before AW 0x08 -> wready=0 until response done; exactly one mem_wr_valid, with data 0x12345678 and addr 0x08.
REQ-019 AW 0x06 or wstrb=4'h3 -> no mem_wr_valid; bresp=10; bvalid held through 5 cycles of bready=0.
REQ-020 AR 0x0C with mem_rd_data=0xCAFEF00D -> mem_rd_valid one cycle later with addr 0x0C; rvalid two cycles after handshake, rdata=0xCAFEF00D, rresp=00; rready held 0 for 4 cycles -> rdata stable.
REQ-021 Concurrent write to 0x10 and read of 0x14 -> both complete with correct data; no cross-corruption.
REQ-022 aresetn pulsed low while bvalid=1, and separately in R_FETCH -> all outputs 0 during reset; no strobe afterwards; the next transaction completes normally.
